syncfifo: RTL and testbench

SYNCFIFO -- requirements
Module: syncfifo

---
 rtl/syncfifo_pkg.sv | 12 +
 rtl/syncfifo_ram.sv | 40 ++++
 rtl/syncfifo.sv | 83 ++++++++
 tb/tb_syncfifo.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/syncfifo_pkg.sv
// Shared definitions for the synchronous FIFO slice.
package syncfifo_pkg;

    // Accepted-operation classification for one clock edge, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/syncfifo_ram.sv
// Simple dual-port storage: synchronous write, synchronous read with enable.
// The read register resets to zero so the FIFO output is defined after reset.
module syncfifo_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port: store the word on an enabled edge; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read port: load the addressed word on an enabled edge, otherwise hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/syncfifo.sv
// Synchronous FIFO: pointer, occupancy and flag control around syncfifo_ram.
// Capacity is one less than the array depth so a full FIFO never has
// equal read and write pointers.
module syncfifo
    import syncfifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clock,
    input  logic                  fifo_rst,
    input  logic                  read_enable,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] fifo_counter
);

    localparam logic [ADDR_WIDTH-1:0] CAPACITY = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic                  push;
    logic                  pop;
    fifo_op_e              op;

    // Flags from occupancy, accept qualification and next-state computation.
    always_comb begin
        full     = (count_q == CAPACITY);
        empty    = (count_q == '0);
        push     = write_enable && !full;
        pop      = read_enable && !empty;
        op       = fifo_op_e'({push, pop});
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end
        case (op)
            OP_PUSH: count_d = count_q + ONE;
            OP_POP:  count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or posedge fifo_rst) begin
        if (fifo_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign fifo_counter = count_q;

    syncfifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clock),
        .rst_i   (fifo_rst),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (write_data),
        .re_i    (pop),
        .raddr_i (rd_ptr_q),
        .rdata_o (read_data)
    );

endmodule

// File: tb/tb_syncfifo.sv
// Randomized self-checking bench for syncfifo against a queue-based model.
module tb_syncfifo;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 9;
    localparam int unsigned CAP = 511;

    logic          clock = 1'b0;
    logic          fifo_rst = 1'b0;
    logic          read_enable = 1'b0;
    logic          write_enable = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic [DW-1:0] read_data;
    logic          full;
    logic          empty;
    logic [AW-1:0] fifo_counter;

    int unsigned   checks = 0;
    int unsigned   errors = 0;

    // Reference model: FIFO contents and the last popped word.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_rd = '0;

    syncfifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clock        (clock),
        .fifo_rst     (fifo_rst),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_data    (read_data),
        .full         (full),
        .empty        (empty),
        .fifo_counter (fifo_counter)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(fifo_counter), 32'(model_q.size()));
        check({tag, "_full"},  32'(full),  32'(model_q.size() == CAP));
        check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, "_rd"},    32'(read_data), 32'(exp_rd));
    endtask

    // Drive one cycle of enables, update the model at the edge, check on the falling edge.
    task automatic step(input string tag, input logic we, input logic re, input logic [DW-1:0] wd);
        bit w_ok;
        bit r_ok;
        write_enable = we;
        read_enable  = re;
        write_data   = wd;
        @(posedge clock);
        w_ok = we && (model_q.size() < CAP);
        r_ok = re && (model_q.size() > 0);
        if (r_ok) exp_rd = model_q.pop_front();
        if (w_ok) model_q.push_back(wd);
        @(negedge clock);
        write_enable = 1'b0;
        read_enable  = 1'b0;
        check_state(tag);
    endtask

    // Asynchronous reset pulse, checked before any clock edge and before release.
    task automatic do_reset(input string tag);
        @(negedge clock);
        #1;
        fifo_rst = 1'b1;
        model_q.delete();
        exp_rd = '0;
        #1;
        check_state({tag, "_async"});
        @(negedge clock);
        check_state({tag, "_held"});
        fifo_rst = 1'b0;
    endtask

    initial begin
        int unsigned wp;
        int unsigned rp;

        do_reset("rst0");

        // Single word round trip.
        step("w_a5", 1'b1, 1'b0, 8'hA5);
        step("idle", 1'b0, 1'b0, 8'h00);
        check("one_count", 32'(fifo_counter), 32'd1);
        step("r_a5", 1'b0, 1'b1, 8'h00);
        check("a5_data", 32'(read_data), 32'hA5);
        check("a5_empty", 32'(empty), 32'd1);

        // Ten back-to-back writes, ten separate reads.
        for (int i = 0; i < 10; i++) step("burst_w", 1'b1, 1'b0, 8'(8'h10 + i));
        check("burst_count", 32'(fifo_counter), 32'd10);
        for (int i = 0; i < 10; i++) begin
            step("burst_r", 1'b0, 1'b1, 8'h00);
            check("burst_order", 32'(read_data), 32'(8'h10 + i));
            step("burst_gap", 1'b0, 1'b0, 8'h00);
        end

        // Both enables while empty: only the write goes in.
        step("both_empty", 1'b1, 1'b1, 8'h3C);
        step("drain1", 1'b0, 1'b1, 8'h00);

        // Simultaneous push/pop keeps occupancy steady.
        for (int i = 0; i < 5; i++) step("pre5", 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 10; i++) begin
            step("both5", 1'b1, 1'b1, 8'($urandom));
            check("steady5", 32'(fifo_counter), 32'd5);
        end

        // Fill to capacity from reset; extra write is dropped.
        do_reset("rst1");
        for (int i = 0; i < 512; i++) step("fill", 1'b1, 1'b0, 8'(i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(fifo_counter), 32'd511);
        step("over", 1'b1, 1'b0, 8'hFF);
        check("over_count", 32'(fifo_counter), 32'd511);
        step("both_full", 1'b1, 1'b1, 8'hEE);
        check("first_out", 32'(read_data), 32'h00);
        check("both_full_count", 32'(fifo_counter), 32'd510);

        // Drain fully, then an extra read while empty.
        while (model_q.size() > 0) step("drain", 1'b0, 1'b1, 8'h00);
        step("under", 1'b0, 1'b1, 8'h00);

        // Random enables with flag invariants.
        for (int i = 0; i < 100; i++) begin
            step("rand100", 1'($urandom), 1'($urandom), 8'($urandom));
            check("not_both", 32'(full && empty), 32'd0);
            check("cnt_le_cap", 32'(int'(fifo_counter) <= CAP), 32'd1);
        end

        // Reset mid-operation discards contents.
        for (int i = 0; i < 20; i++) step("pre_rst", 1'b1, 1'b0, 8'($urandom));
        do_reset("rst2");
        step("post_rst_r", 1'b0, 1'b1, 8'h00);
        step("post_rst_w", 1'b1, 1'b0, 8'h77);
        step("post_rst_rd", 1'b0, 1'b1, 8'h00);

        // Long biased random run: fill-heavy then drain-heavy phases wrap the pointers.
        for (int ph = 0; ph < 6; ph++) begin
            wp = (ph % 2 == 0) ? 85 : 15;
            rp = (ph % 2 == 0) ? 15 : 85;
            for (int i = 0; i < 700; i++) begin
                step("long", 1'($urandom_range(99) < wp), 1'($urandom_range(99) < rp), 8'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
